// File: rtl/uart_pkg.sv
// Shared definitions for the Uart8 receive controller: state encoding and
// default serial timing.
package uart_pkg;

  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    ARMED     = 2'd1,
    RECEIVING = 2'd2,
    RECOVER   = 2'd3
  } rxState_t;

  localparam int CLOCK_RATE  = 12000000;
  localparam int BAUD        = 9600;
  localparam int FRAME_BITS  = 10;
  localparam int IDLE_CYCLES = (CLOCK_RATE / BAUD) * FRAME_BITS;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Handshake bundle between the Uart8 receiver, the receive controller and
// the byte consumer. The controller takes the slave view.
interface uart_rx_ctrl_if;

  logic       enable;
  logic       flush;
  logic       rxLine;
  logic       uartRxEn;
  logic       uartRxBusy;
  logic       uartRxDone;
  logic       uartRxErr;
  logic [7:0] uartRxByte;
  logic       outValid;
  logic       outReady;
  logic [7:0] outByte;

  modport slave (
    input  enable, flush, rxLine, uartRxBusy, uartRxDone, uartRxErr,
           uartRxByte, outReady,
    output uartRxEn, outValid, outByte
  );

  modport master (
    output enable, flush, rxLine, uartRxBusy, uartRxDone, uartRxErr,
           uartRxByte, outReady,
    input  uartRxEn, outValid, outByte
  );

endinterface

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO. Head byte is read straight from storage, so a
// push becomes visible the cycle after it is written (no fall-through).
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [7:0]              pushData,
  output logic [7:0]              headData,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;
  logic          doPush;
  logic          doPop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign headData = mem_q[rdPtr_q];

  // A pop from an empty FIFO is ignored; a push into a full FIFO only lands
  // if a pop frees the slot in the same cycle.
  always_comb begin
    doPop  = pop && !empty;
    doPush = push && (!full || doPop);
  end

  // Storage, pointers and occupancy; flush overrides any same-cycle push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= pushData;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (doPop) rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences the Uart8 receiver: arms it on host enable, stores good bytes in
// a FIFO, counts good and errored frames, and after an error keeps the
// receiver off until the line has been idle for a full frame time.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int IDLE_CYCLES = 12500,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  uart_rx_ctrl_if.slave                bus,
  output logic [$clog2(FIFO_DEPTH):0]  fifoCount,
  output logic                         overflow,
  output logic [CNT_WIDTH-1:0]         frameCount,
  output logic [CNT_WIDTH-1:0]         errCount,
  output logic [1:0]                   state
);

  import uart_pkg::*;

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

  rxState_t             state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [IW-1:0]        idleCnt_q, idleCnt_d;
  logic [CNT_WIDTH-1:0] frameCnt_q, frameCnt_d;
  logic [CNT_WIDTH-1:0] errCnt_q, errCnt_d;
  logic                 overflow_q, overflow_d;
  logic                 listening;
  logic                 goodFrame;
  logic                 badFrame;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 fifoPop;

  assign listening = (state_q == ARMED) || (state_q == RECEIVING);
  assign goodFrame = listening && bus.uartRxDone && !bus.uartRxErr;
  assign badFrame  = listening && bus.uartRxErr;
  assign fifoPop   = bus.outReady && !fifoEmpty;

  assign bus.uartRxEn = listening;
  assign bus.outValid = !fifoEmpty;
  assign overflow     = overflow_q;
  assign frameCount   = frameCnt_q;
  assign errCount     = errCnt_q;
  assign state        = state_q;

  // Two-flop synchronizer on the raw line; presets high so a reset never
  // looks like activity on the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rxLine;
      sync2_q <= sync1_q;
    end
  end

  // Controller state, idle counter, frame/error counters and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= DISABLED;
      idleCnt_q  <= '0;
      frameCnt_q <= '0;
      errCnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idleCnt_q  <= idleCnt_d;
      frameCnt_q <= frameCnt_d;
      errCnt_q   <= errCnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Next state: frame completion/error is honoured in ARMED as well as
  // RECEIVING so a missed busy pulse never loses a frame; recovery leaves
  // exactly when the synchronized line has been high for IDLE_CYCLES clocks.
  always_comb begin
    state_d   = state_q;
    idleCnt_d = idleCnt_q;
    case (state_q)
      DISABLED: begin
        if (bus.enable) state_d = ARMED;
      end
      ARMED, RECEIVING: begin
        if (badFrame) begin
          state_d   = RECOVER;
          idleCnt_d = '0;
        end else if (goodFrame) begin
          state_d = bus.enable ? ARMED : DISABLED;
        end else if (state_q == ARMED) begin
          if (!bus.enable)         state_d = DISABLED;
          else if (bus.uartRxBusy) state_d = RECEIVING;
        end
      end
      RECOVER: begin
        if (sync2_q) begin
          if (idleCnt_q == IDLE_LAST) begin
            state_d   = bus.enable ? ARMED : DISABLED;
            idleCnt_d = '0;
          end else begin
            idleCnt_d = idleCnt_q + 1'b1;
          end
        end else begin
          idleCnt_d = '0;
        end
      end
      default: state_d = DISABLED;
    endcase
  end

  // Frame counter wraps, error counter saturates, and overflow is set only
  // when a good byte is actually dropped; flush clears it.
  always_comb begin
    frameCnt_d = frameCnt_q;
    errCnt_d   = errCnt_q;
    overflow_d = overflow_q;
    if (goodFrame) frameCnt_d = frameCnt_q + 1'b1;
    if (badFrame && (errCnt_q != '1)) errCnt_d = errCnt_q + 1'b1;
    if (bus.flush) overflow_d = 1'b0;
    else if (goodFrame && fifoFull && !fifoPop) overflow_d = 1'b1;
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (goodFrame),
    .pop      (bus.outReady),
    .flush    (bus.flush),
    .pushData (bus.uartRxByte),
    .headData (bus.outByte),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed scenarios followed by randomized
// cycle-level traffic, compared against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int IDLE  = 12500;

  localparam int S_DIS = 0;
  localparam int S_ARM = 1;
  localparam int S_RX  = 2;
  localparam int S_REC = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    fifoCount;
  logic          overflow;
  logic [CW-1:0] frameCount;
  logic [CW-1:0] errCount;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  int         mState;
  int         mIdle;
  bit         mOvf;
  int         mFrames;
  int         mErrs;
  bit         hist0, hist1;
  bit         quiet;

  always #5 clk = ~clk;

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .IDLE_CYCLES (IDLE),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .fifoCount  (fifoCount),
    .overflow   (overflow),
    .frameCount (frameCount),
    .errCount   (errCount),
    .state      (state)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mState  = S_DIS;
    mIdle   = 0;
    mOvf    = 0;
    mFrames = 0;
    mErrs   = 0;
    hist0   = 1;
    hist1   = 1;
  endtask

  // Reference behaviour for one clock edge, from the current inputs.
  task automatic modelStep();
    bit on, good, err, popNow, lineNow;
    on      = (mState == S_ARM) || (mState == S_RX);
    good    = on && bus.uartRxDone && !bus.uartRxErr;
    err     = on && bus.uartRxErr;
    popNow  = (mq.size() != 0) && bus.outReady;
    lineNow = hist1;
    hist1   = hist0;
    hist0   = bus.rxLine;

    if (bus.flush) begin
      mq.delete();
      mOvf = 0;
    end else begin
      if (popNow) void'(mq.pop_front());
      if (good) begin
        if (mq.size() < DEPTH) mq.push_back(bus.uartRxByte);
        else mOvf = 1;
      end
    end
    if (good) mFrames = (mFrames + 1) % 65536;
    if (err && mErrs < 65535) mErrs++;

    case (mState)
      S_DIS: if (bus.enable) mState = S_ARM;
      S_ARM, S_RX: begin
        if (err) begin
          mState = S_REC;
          mIdle  = 0;
        end else if (good) mState = bus.enable ? S_ARM : S_DIS;
        else if (mState == S_ARM) begin
          if (!bus.enable) mState = S_DIS;
          else if (bus.uartRxBusy) mState = S_RX;
        end
      end
      default: begin
        if (lineNow) begin
          if (mIdle + 1 == IDLE) begin
            mState = bus.enable ? S_ARM : S_DIS;
            mIdle  = 0;
          end else mIdle++;
        end else mIdle = 0;
      end
    endcase
  endtask

  task automatic checkAll();
    checkOutput("state", state, mState);
    checkOutput("uartRxEn", bus.uartRxEn, (mState == S_ARM) || (mState == S_RX));
    checkOutput("outValid", bus.outValid, mq.size() != 0);
    if (mq.size() != 0) checkOutput("outByte", bus.outByte, mq[0]);
    checkOutput("fifoCount", fifoCount, mq.size());
    checkOutput("overflow", overflow, mOvf);
    checkOutput("frameCount", frameCount, mFrames);
    checkOutput("errCount", errCount, mErrs);
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    if (!quiet) checkAll();
  endtask

  task automatic deliverFrame(input logic [7:0] data, input bit err,
                              input int busyCycles, input bit readyOnDone);
    bus.uartRxDone = 0;
    bus.uartRxErr  = 0;
    for (int i = 0; i < busyCycles; i++) begin
      bus.uartRxBusy = 1;
      applyStimulus();
    end
    bus.uartRxBusy = 0;
    bus.uartRxDone = 1;
    bus.uartRxErr  = err;
    bus.uartRxByte = data;
    bus.outReady   = readyOnDone;
    applyStimulus();
    bus.uartRxDone = 0;
    bus.uartRxErr  = 0;
    bus.outReady   = 0;
  endtask

  task automatic drainExpect(input string tag, input int first, input int n);
    bus.outReady = 1;
    for (int i = 0; i < n; i++) begin
      checkOutput(tag, bus.outByte, first + i);
      applyStimulus();
    end
    bus.outReady = 0;
  endtask

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int enHigh;
    int waitCnt;
    int fcBefore;
    int errBudget;

    bus.enable = 0; bus.flush = 0; bus.rxLine = 1; bus.uartRxBusy = 0;
    bus.uartRxDone = 0; bus.uartRxErr = 0; bus.uartRxByte = 0; bus.outReady = 0;
    quiet = 0;
    modelReset();

    #12;
    checkOutput("rst state", state, S_DIS);
    checkOutput("rst uartRxEn", bus.uartRxEn, 0);
    checkOutput("rst outValid", bus.outValid, 0);
    checkOutput("rst outByte", bus.outByte, 0);
    checkOutput("rst fifoCount", fifoCount, 0);
    checkOutput("rst overflow", overflow, 0);
    checkOutput("rst frameCount", frameCount, 0);
    checkOutput("rst errCount", errCount, 0);

    @(posedge clk); #1;
    reset = 1;
    applyStimulus();
    bus.enable = 1;
    applyStimulus();
    checkOutput("arm state", state, S_ARM);
    checkOutput("arm uartRxEn", bus.uartRxEn, 1);

    deliverFrame(8'hB5, 0, 3, 0);
    checkOutput("b5 outValid", bus.outValid, 1);
    checkOutput("b5 outByte", bus.outByte, 8'hB5);
    checkOutput("b5 fifoCount", fifoCount, 1);
    checkOutput("b5 frameCount", frameCount, 1);
    bus.outReady = 1;
    applyStimulus();
    bus.outReady = 0;
    checkOutput("b5 popped", bus.outValid, 0);

    deliverFrame(8'h3C, 0, 2, 1);
    bus.rxLine = 0;
    deliverFrame(8'hEE, 1, 2, 0);
    checkOutput("err errCount", errCount, 1);
    checkOutput("err state", state, S_REC);
    quiet  = 1;
    enHigh = 0;
    for (int i = 0; i < 20000; i++) begin
      applyStimulus();
      if (bus.uartRxEn) enHigh++;
    end
    quiet = 0;
    checkOutput("recover rxEn held low", enHigh, 0);
    checkAll();
    bus.rxLine = 1;
    quiet   = 1;
    waitCnt = 0;
    while (waitCnt < IDLE + 100) begin
      applyStimulus();
      waitCnt++;
      if (bus.uartRxEn) break;
    end
    quiet = 0;
    checkOutput("rearm delay", waitCnt, IDLE + 2);
    checkAll();

    bus.outReady = 1;
    applyStimulus();
    bus.outReady = 0;
    fcBefore = mFrames;
    for (int i = 1; i <= 9; i++) deliverFrame(8'(i), 0, 2, 0);
    checkOutput("ovf fifoCount", fifoCount, 8);
    checkOutput("ovf flag", overflow, 1);
    checkOutput("ovf frameCount", frameCount, fcBefore + 9);
    drainExpect("ovf drain", 1, 8);
    checkOutput("ovf drained", bus.outValid, 0);
    checkOutput("ovf still set", overflow, 1);
    bus.flush = 1;
    applyStimulus();
    bus.flush = 0;
    checkOutput("flush overflow", overflow, 0);

    for (int i = 0; i < 8; i++) deliverFrame(8'(8'h10 + i), 0, 1, 0);
    deliverFrame(8'h18, 0, 2, 1);
    checkOutput("pushpop fifoCount", fifoCount, 8);
    checkOutput("pushpop overflow", overflow, 0);
    drainExpect("pushpop drain", 8'h11, 8);

    bus.uartRxBusy = 1;
    applyStimulus();
    bus.enable = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("dropEn uartRxEn", bus.uartRxEn, 1);
    end
    deliverFrame(8'h5A, 0, 0, 0);
    checkOutput("dropEn state", state, S_DIS);
    checkOutput("dropEn outByte", bus.outByte, 8'h5A);
    bus.enable = 1;
    bus.outReady = 1;
    applyStimulus();
    bus.outReady = 0;

    errBudget = 2;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) bus.enable = ~bus.enable;
      bus.flush      = ($urandom_range(0, 39) == 0);
      bus.outReady   = ($urandom_range(0, 2) == 0);
      bus.uartRxBusy = $urandom_range(0, 1);
      bus.uartRxDone = ($urandom_range(0, 3) == 0);
      bus.uartRxByte = 8'($urandom);
      bus.rxLine     = ($urandom_range(0, 9) != 0);
      bus.uartRxErr  = (errBudget > 0) && ($urandom_range(0, 299) == 0);
      if (bus.uartRxErr && (mState == S_ARM || mState == S_RX)) errBudget--;
      applyStimulus();
      if (mState == S_REC) begin
        bus.rxLine = 1; bus.uartRxDone = 0; bus.uartRxErr = 0;
        bus.uartRxBusy = 0; bus.flush = 0;
        quiet   = 1;
        waitCnt = 0;
        while (mState == S_REC && waitCnt < IDLE + 10) begin
          applyStimulus();
          waitCnt++;
        end
        quiet = 0;
        checkOutput("rand recover bound", mState == S_REC, 0);
        checkAll();
      end
    end

    bus.enable = 1; bus.flush = 0; bus.outReady = 0; bus.rxLine = 1;
    bus.uartRxBusy = 0; bus.uartRxDone = 0; bus.uartRxErr = 0;
    applyStimulus();
    applyStimulus();
    deliverFrame(8'h77, 1, 1, 0);
    quiet = 1;
    for (int i = 0; i < 100; i++) applyStimulus();
    quiet = 0;
    checkOutput("midrec state", state, S_REC);
    #2;
    reset = 0;
    #1;
    modelReset();
    checkOutput("async state", state, S_DIS);
    checkOutput("async uartRxEn", bus.uartRxEn, 0);
    checkOutput("async frameCount", frameCount, 0);
    checkOutput("async errCount", errCount, 0);
    checkOutput("async fifoCount", fifoCount, 0);
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
